// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CSR_DRAIN = 2'd1,
        CSR_ISSUE = 2'd2,
        REDIRECT  = 2'd3
    } hz_state_e;

    localparam int         CNT_W_DEFAULT = 2;
    localparam logic [4:0] X0            = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters with two read lookups
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] look_a_idx,
    input  logic [IDX_W-1:0] look_b_idx,
    output logic [CNT_W-1:0] pend_a,
    output logic [CNT_W-1:0] pend_b,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pend_q [NREG];
    logic [CNT_W-1:0] pend_d [NREG];

    always_comb begin
        fault = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
            // Entry 0 stays 0 so x0 never looks pending; same-register inc+dec nets out.
            if (i != 0) begin
                if (inc_en && inc_idx == IDX_W'(i) && !(dec_en && dec_idx == IDX_W'(i))) begin
                    if (pend_q[i] == CNT_MAX) fault = 1'b1;
                    else                      pend_d[i] = pend_q[i] + 1'b1;
                end else if (dec_en && dec_idx == IDX_W'(i) && !(inc_en && inc_idx == IDX_W'(i))) begin
                    if (pend_q[i] == '0) fault = 1'b1;
                    else                 pend_d[i] = pend_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_a = pend_q[look_a_idx];
    assign pend_b = pend_q[look_b_idx];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID issue/stall/flush decision for the 5-stage pipeline
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_csr,
    input  logic       ex_redirect,
    input  logic       wb_retire,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic       issue,
    output logic       stall,
    output logic       flush_id,
    output logic       bubble_ex,
    output logic       csr_busy,
    output logic       err
);

    localparam int               FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] INFL_MAX = '1;

    hz_state_e        state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] pend_rs1, pend_rs2;
    logic             sb_fault, infl_fault, raw, sb_inc, sb_dec;

    reg_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W),
        .IDX_W (5)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (sb_inc),
        .inc_idx    (id_rd),
        .dec_en     (sb_dec),
        .dec_idx    (wb_rd),
        .look_a_idx (id_rs1),
        .look_b_idx (id_rs2),
        .pend_a     (pend_rs1),
        .pend_b     (pend_rs2),
        .fault      (sb_fault)
    );

    // A register retiring this very cycle still reads as pending: the write lands at the edge.
    always_comb begin
        raw       = (id_uses_rs1 && id_rs1 != X0 && pend_rs1 != '0) ||
                    (id_uses_rs2 && id_rs2 != X0 && pend_rs2 != '0);
        flush_id  = ex_redirect || (state_q == REDIRECT);
        stall     = !flush_id && id_valid &&
                    (raw || state_q == CSR_DRAIN || (state_q == RUN && id_csr));
        issue     = id_valid && !stall && !flush_id;
        bubble_ex = (id_valid || flush_id) && !issue;
        csr_busy  = (state_q == CSR_DRAIN) || (state_q == CSR_ISSUE);
        err       = err_q;
        sb_inc    = issue && id_reg_write && id_rd != X0;
        sb_dec    = wb_retire && wb_reg_write && wb_rd != X0;
    end

    always_comb begin
        infl_fault = 1'b0;
        inflight_d = inflight_q;
        if (issue && !wb_retire) begin
            if (inflight_q == INFL_MAX) infl_fault = 1'b1;
            else                        inflight_d = inflight_q + 1'b1;
        end else if (wb_retire && !issue) begin
            if (inflight_q == '0) infl_fault = 1'b1;
            else                  inflight_d = inflight_q - 1'b1;
        end
        err_d = err_q || sb_fault || infl_fault;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect) begin
            flush_cnt_d = FC_LOAD;
            state_d     = (FC_LOAD == '0) ? RUN : REDIRECT;
        end else begin
            case (state_q)
                RUN:       if (id_valid && id_csr) state_d = CSR_DRAIN;
                CSR_DRAIN: if (inflight_q == '0 && !wb_retire) state_d = CSR_ISSUE;
                CSR_ISSUE: if (issue) state_d = RUN;
                REDIRECT: begin
                    if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q <= FC_W'(1)) state_d = RUN;
                end
                default:   state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector-table bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    // exp = {issue, stall, flush_id, bubble_ex, csr_busy, err}; c1 = {check, flush_id of FLUSH_CYCLES=1 copy}
    typedef struct {
        logic       rst;
        logic       valid;
        logic       u1;
        logic [4:0] rs1;
        logic       u2;
        logic [4:0] rs2;
        logic       rw;
        logic [4:0] rd;
        logic       csr;
        logic       redir;
        logic       ret;
        logic       wrw;
        logic [4:0] wrd;
        logic [5:0] exp;
        logic [1:0] c1;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_csr;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       ex_redirect, wb_retire, wb_reg_write;
    logic       issue, stall, flush_id, bubble_ex, csr_busy, err;
    logic       issue1, stall1, flush_id1, bubble_ex1, csr_busy1, err1;

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_q [$];
    logic [1:0] c1_q  [$];
    vec_t       tbl   [$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREG(32), .CNT_W(2), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_csr(id_csr), .ex_redirect(ex_redirect),
        .wb_retire(wb_retire), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .issue(issue), .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .csr_busy(csr_busy), .err(err)
    );

    pipe_hazard_ctrl #(.NREG(32), .CNT_W(2), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_csr(id_csr), .ex_redirect(ex_redirect),
        .wb_retire(wb_retire), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .issue(issue1), .stall(stall1), .flush_id(flush_id1), .bubble_ex(bubble_ex1),
        .csr_busy(csr_busy1), .err(err1)
    );

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, expv);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        logic [5:0] e;
        logic [1:0] c;
        reset        = v.rst;
        id_valid     = v.valid;
        id_uses_rs1  = v.u1;
        id_rs1       = v.rs1;
        id_uses_rs2  = v.u2;
        id_rs2       = v.rs2;
        id_reg_write = v.rw;
        id_rd        = v.rd;
        id_csr       = v.csr;
        ex_redirect  = v.redir;
        wb_retire    = v.ret;
        wb_reg_write = v.wrw;
        wb_rd        = v.wrd;
        exp_q.push_back(v.exp);
        c1_q.push_back(v.c1);
        @(negedge clk);
        e = exp_q.pop_front();
        c = c1_q.pop_front();
        chk(nm, {issue, stall, flush_id, bubble_ex, csr_busy, err}, e);
        if (c[1]) chk({nm, "_fc1_flush"}, {5'b0, flush_id1}, {5'b0, c[0]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1;
        {id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_csr} = '0;
        {ex_redirect, wb_retire, wb_reg_write} = '0;
        {id_rs1, id_rs2, id_rd, wb_rd} = '0;
        @(posedge clk);
        #1;

        //            rst valid u1 rs1  u2 rs2  rw rd  csr rdr ret wrw wrd  exp        c1
        tbl.push_back('{H, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b000000, 2'b00}); // in reset
        // RAW on x5 incl. same-cycle retire
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd5, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, H, 5'd5, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, H, 5'd5, L, 5'd0, L, 5'd0, L, L, H, H, 5'd5, 6'b010100, 2'b00});
        tbl.push_back('{L, H, H, 5'd5, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, L, 5'd0, 6'b000000, 2'b00});
        // x0 never pending
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, H, 5'd0, H, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, H, 5'd0, 6'b000000, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, L, 5'd0, 6'b000000, 2'b00});
        // two writers of x7, reader waits for the second retire
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd7, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd7, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, H, 5'd7, L, 5'd0, L, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, H, 5'd7, L, 5'd0, L, L, H, H, 5'd7, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, H, 5'd7, L, 5'd0, L, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, H, 5'd7, L, 5'd0, L, L, H, H, 5'd7, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, H, 5'd7, L, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, L, 5'd0, 6'b000000, 2'b00});
        // CSR drain behind three in-flight writers
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd1, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd2, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd3, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, H, H, 5'd1, 6'b010110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, H, H, 5'd2, 6'b010110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, H, H, 5'd3, 6'b010110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b100010, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, L, 5'd0, 6'b000000, 2'b00});
        // redirect during a RAW stall
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd4, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, H, 5'd4, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, H, 5'd4, L, 5'd0, L, 5'd0, L, H, L, L, 5'd0, 6'b001100, 2'b11});
        tbl.push_back('{L, H, H, 5'd4, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b001100, 2'b10});
        tbl.push_back('{L, H, H, 5'd4, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, H, 5'd4, L, 5'd0, L, 5'd0, L, L, H, H, 5'd4, 6'b010100, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b000000, 2'b00});
        // redirect abandons a CSR drain
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, H, 5'd6, L, L, L, L, 5'd0, 6'b100000, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010100, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, H, L, L, 5'd0, 6'b001110, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b001100, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, H, 5'd6, 6'b000000, 2'b00});
        // underflow on x9 sets sticky err, counter stays at 0
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, H, H, 5'd9, 6'b000000, 2'b00});
        tbl.push_back('{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b000001, 2'b00});
        tbl.push_back('{L, H, H, 5'd9, L, 5'd0, H, 5'd9, L, L, L, L, 5'd0, 6'b100001, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010101, 2'b00});
        tbl.push_back('{L, H, L, 5'd0, L, 5'd0, L, 5'd0, H, L, L, L, 5'd0, 6'b010111, 2'b00});
        // reset mid-drain clears err, state and scoreboard
        tbl.push_back('{H, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b000000, 2'b00});
        tbl.push_back('{L, H, H, 5'd9, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00});

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // In-flight overflow: one already in flight, three more issues push past the max of 3
        for (int i = 0; i < 3; i++) begin
            v = '{L, H, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b100000, 2'b00};
            apply(v, $sformatf("ovf_issue%0d", i));
        end
        v = '{L, L, L, 5'd0, L, 5'd0, L, 5'd0, L, L, L, L, 5'd0, 6'b000001, 2'b00};
        apply(v, "ovf_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
